// File: rtl/lcd_bus_sequencer.sv
// HD44780-style LCD bus master: optional busy-flag polling followed by one
// byte transfer, with E-strobe setup/pulse/hold timing generated in hardware.
module lcd_bus_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned POLL_MAX  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic       reqRS,
  input  logic       reqRead,
  input  logic [7:0] reqData,
  input  logic       pollBusy,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       timeout,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdE,
  output logic [7:0] lcdDataOut,
  output logic       lcdDataOE,
  input  logic [7:0] lcdDataIn
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned POLL_W  = 10;
  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, P_SETUP, P_PULSE, P_HOLD, T_SETUP, T_PULSE, T_HOLD, DONE
  } state_t;

  typedef struct packed {
    logic              rs;
    logic              rd;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d, poll_inc;
  logic              busy_q, busy_d;
  req_t              req_q, req_d;
  logic              timeout_d;
  logic              ready_d, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rs_d, rw_d, e_d, oe_d;
  logic [DATA_W-1:0] dout_d;
  logic              last;

  // Number of cycles (minus one) a timed state lasts; loaded on state entry.
  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      P_SETUP, T_SETUP: dur = CNT_W'(SETUP_CYC - 1);
      P_PULSE, T_PULSE: dur = CNT_W'(PULSE_CYC - 1);
      P_HOLD,  T_HOLD:  dur = CNT_W'(HOLD_CYC - 1);
      default:          dur = '0;
    endcase
  endfunction

  // Next state, phase timing, and the registered-output values for the next cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    busy_d      = busy_q;
    req_d       = req_q;
    timeout_d   = timeout;
    rsp_data_d  = rspData;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rs_d        = 1'b0;
    rw_d        = 1'b0;
    e_d         = 1'b0;
    oe_d        = 1'b0;
    dout_d      = '0;
    last        = (cnt_q == '0);
    poll_inc    = (poll_q >= POLL_W'(POLL_MAX)) ? poll_q : poll_q + POLL_W'(1);

    unique case (state_q)
      IDLE: begin
        if (reqValid && reqReady) begin
          req_d   = '{rs: reqRS, rd: reqRead, data: reqData};
          poll_d  = '0;
          state_d = pollBusy ? P_SETUP : T_SETUP;
        end
      end
      P_SETUP: if (last) state_d = P_PULSE;
      P_PULSE: begin
        if (last) begin
          busy_d  = lcdDataIn[7];
          state_d = P_HOLD;
        end
      end
      P_HOLD: begin
        if (last) begin
          if (!busy_q) begin
            state_d = T_SETUP;
          end else begin
            poll_d = poll_inc;
            if (poll_inc >= POLL_W'(POLL_MAX)) begin
              timeout_d = 1'b1;
              state_d   = T_SETUP;
            end else begin
              state_d = P_SETUP;
            end
          end
        end
      end
      T_SETUP: if (last) state_d = T_PULSE;
      T_PULSE: begin
        if (last) begin
          if (req_q.rd) rsp_data_d = lcdDataIn;
          state_d = T_HOLD;
        end
      end
      T_HOLD: if (last) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase

    // Reload the phase counter on every state change, otherwise count down.
    if (state_d != state_q) begin
      cnt_d = dur(state_d);
    end else if (!last) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Bus pins reflect the state being entered, so they change only on entry.
    case (state_d)
      IDLE:            ready_d = 1'b1;
      P_SETUP, P_HOLD: rw_d    = 1'b1;
      P_PULSE: begin
        rw_d = 1'b1;
        e_d  = 1'b1;
      end
      T_SETUP, T_PULSE, T_HOLD: begin
        rs_d   = req_d.rs;
        rw_d   = req_d.rd;
        oe_d   = ~req_d.rd;
        dout_d = req_d.rd ? '0 : req_d.data;
        e_d    = (state_d == T_PULSE);
      end
      DONE:    rsp_valid_d = req_d.rd;
      default: ;
    endcase
  end

  // State and output registers; reset drops every pin immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      poll_q     <= '0;
      busy_q     <= 1'b0;
      req_q      <= '0;
      reqReady   <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      timeout    <= 1'b0;
      lcdRS      <= 1'b0;
      lcdRW      <= 1'b0;
      lcdE       <= 1'b0;
      lcdDataOut <= '0;
      lcdDataOE  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      reqReady   <= ready_d;
      rspValid   <= rsp_valid_d;
      rspData    <= rsp_data_d;
      timeout    <= timeout_d;
      lcdRS      <= rs_d;
      lcdRW      <= rw_d;
      lcdE       <= e_d;
      lcdDataOut <= dout_d;
      lcdDataOE  <= oe_d;
    end
  end

endmodule
